// File: rtl/dm_cache.sv
// Direct-mapped write-through cache between a CPU port and a synchronous RAM.
// Read hits complete in the request cycle; misses fill one word, writes always go through.
//
// state       | meaning
// IDLE        | accept requests, read hits answered combinationally
// FILL        | mem_rd strobe for mem_lat cycles, then capture mem_rdata
// REFILL_DONE | present filled word with odv
// WRITE       | one-cycle mem_wr strobe, update line on hit, odv
module dm_cache #(
    parameter int d_width  = 16,
    parameter int a_width  = 8,
    parameter int idx_bits = 2,
    parameter int mem_lat  = 1
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic [a_width-1:0] cpu_addr,
    input  logic [d_width-1:0] cpu_wdata,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    output logic [d_width-1:0] cpu_rdata,
    output logic               odv,
    output logic [a_width-1:0] mem_addr,
    output logic [d_width-1:0] mem_wdata,
    output logic               mem_rd,
    output logic               mem_wr,
    input  logic [d_width-1:0] mem_rdata
);
    localparam int lines   = 1 << idx_bits;
    localparam int t_width = a_width - idx_bits;
    localparam logic [2:0] lat_load = 3'(mem_lat);

    typedef enum logic [1:0] {IDLE, FILL, REFILL_DONE, WRITE} state_t;

    state_t             state;
    logic [2:0]         cnt;
    logic [lines-1:0]   valid;
    logic [t_width-1:0] tag_mem  [lines];
    logic [d_width-1:0] data_mem [lines];
    logic               odv_r;
    logic [d_width-1:0] rdata_r;

    logic [idx_bits-1:0] req_idx, reg_idx;
    logic [t_width-1:0]  req_tag, reg_tag;
    logic                req_hit, reg_hit, rd_hit;

    assign req_idx = cpu_addr[idx_bits-1:0];
    assign req_tag = cpu_addr[a_width-1:idx_bits];
    // mem_addr doubles as the registered request address for FILL/WRITE
    assign reg_idx = mem_addr[idx_bits-1:0];
    assign reg_tag = mem_addr[a_width-1:idx_bits];

    assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign reg_hit = valid[reg_idx] && (tag_mem[reg_idx] == reg_tag);
    assign rd_hit  = (state == IDLE) && cpu_rd && !cpu_wr && req_hit;

    assign odv       = rd_hit | odv_r;
    assign cpu_rdata = rd_hit ? data_mem[req_idx] : rdata_r;

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state     <= IDLE;
            cnt       <= '0;
            valid     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_r   <= '0;
            odv_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_wr    <= 1'b1;
                        odv_r     <= 1'b1;
                        state     <= WRITE;
                    end else if (cpu_rd && !req_hit) begin
                        mem_addr <= cpu_addr;
                        mem_rd   <= 1'b1;
                        cnt      <= lat_load;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    // strobe covers the first mem_lat cycles; data arrives on the terminal count
                    if (cnt == 3'd0) begin
                        valid[reg_idx] <= 1'b1;
                        rdata_r        <= mem_rdata;
                        odv_r          <= 1'b1;
                        state          <= REFILL_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1)
                            mem_rd <= 1'b0;
                    end
                end
                REFILL_DONE: begin
                    odv_r <= 1'b0;
                    state <= IDLE;
                end
                WRITE: begin
                    mem_wr <= 1'b0;
                    odv_r  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // tag/data arrays carry no reset; the valid bits alone qualify them
    always_ff @(posedge g_clk) begin
        if (state == FILL && cnt == 3'd0) begin
            tag_mem[reg_idx]  <= reg_tag;
            data_mem[reg_idx] <= mem_rdata;
        end else if (state == WRITE && reg_hit) begin
            data_mem[reg_idx] <= mem_wdata;
        end
    end

endmodule
